// File: rtl/systolic_bs_array.sv
// rtl/systolic_bs_array.sv - bit-serial weight systolic MAC array; SYSTOLIC_PERF_CNT_EN enables cycle_count.
module systolic_bs_array #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int MAX_PREC  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                precision,
    input  logic [15:0]               k_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*ACT_WIDTH-1:0] act_in,
    input  logic [COLS*MAX_PREC-1:0]  w_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH-1:0]      out_data,
    output logic [15:0]               out_idx,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               cycle_count
);
    localparam int DEPTH = ROWS + COLS - 1;
    localparam int NPE   = ROWS * COLS;
    localparam logic [3:0]  MAXP        = 4'(MAX_PREC);
    localparam logic [15:0] FLUSH_SLOTS = 16'(ROWS + COLS - 2);
    localparam logic [15:0] LAST_IDX    = 16'(NPE - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;
    state_t state, state_nxt;

    logic [3:0]  p_reg, bit_cnt;
    logic [15:0] k_reg, term_cnt, flush_cnt, idx_reg;
    logic        slot_active, done_reg;
    // Lane position d holds the term that entered d slots ago; PE(i,j) taps d=i+j.
    logic signed [ACT_WIDTH-1:0] act_pipe [ROWS][DEPTH];
    logic [MAX_PREC-1:0]         w_pipe   [COLS][DEPTH];
    logic signed [ACC_WIDTH-1:0] acc      [NPE];

    logic start_acc, slot_end, boundary, accept, flush_adv, drain_fire, drain_last;

    function automatic logic [3:0] p_clamp(input logic [3:0] p);
        if (p < 4'd2) return 4'd2;
        if (p > MAXP) return MAXP;
        return p;
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] pe_term(
        input logic signed [ACT_WIDTH-1:0] a,
        input logic [MAX_PREC-1:0]         w,
        input logic [3:0]                  b,
        input logic [3:0]                  p
    );
        logic                        w_bit;
        logic signed [ACC_WIDTH-1:0] sh;
        w_bit = |(w & (MAX_PREC'(1) << b));
        sh    = ACC_WIDTH'(a) <<< b;
        if (!w_bit) return '0;
        return (b == p - 4'd1) ? -sh : sh;
    endfunction

    assign start_acc  = (state == IDLE) && start;
    assign slot_end   = slot_active && (bit_cnt == p_reg - 4'd1);
    assign boundary   = !slot_active || slot_end;
    assign in_ready   = (state == COMPUTE) && boundary && (term_cnt < k_reg);
    assign accept     = in_valid && in_ready;
    assign flush_adv  = (state == FLUSH) && slot_end && (flush_cnt < FLUSH_SLOTS);
    assign drain_fire = (state == DRAIN) && out_ready;
    assign drain_last = drain_fire && (idx_reg == LAST_IDX);

    assign out_valid = (state == DRAIN);
    assign out_idx   = idx_reg;
    assign busy      = (state != IDLE);
    assign done      = done_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (k_len == 16'd0) ? DRAIN : COMPUTE;
            COMPUTE: if (accept && (term_cnt + 16'd1 == k_reg)) state_nxt = FLUSH;
            FLUSH:   if (slot_end && (flush_cnt == FLUSH_SLOTS)) state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_reg       <= 4'd2;
            k_reg       <= '0;
            bit_cnt     <= '0;
            term_cnt    <= '0;
            flush_cnt   <= '0;
            idx_reg     <= '0;
            slot_active <= 1'b0;
            done_reg    <= 1'b0;
            for (int n = 0; n < NPE; n++) acc[n] <= '0;
            for (int i = 0; i < ROWS; i++)
                for (int d = 0; d < DEPTH; d++) act_pipe[i][d] <= '0;
            for (int j = 0; j < COLS; j++)
                for (int d = 0; d < DEPTH; d++) w_pipe[j][d] <= '0;
        end else begin
            done_reg <= drain_last;
            if (start_acc) begin
                p_reg       <= p_clamp(precision);
                k_reg       <= k_len;
                bit_cnt     <= '0;
                term_cnt    <= '0;
                flush_cnt   <= '0;
                idx_reg     <= '0;
                slot_active <= 1'b0;
                for (int n = 0; n < NPE; n++) acc[n] <= '0;
                for (int i = 0; i < ROWS; i++)
                    for (int d = 0; d < DEPTH; d++) act_pipe[i][d] <= '0;
                for (int j = 0; j < COLS; j++)
                    for (int d = 0; d < DEPTH; d++) w_pipe[j][d] <= '0;
            end else begin
                if (slot_active)
                    for (int i = 0; i < ROWS; i++)
                        for (int j = 0; j < COLS; j++)
                            acc[i*COLS+j] <= acc[i*COLS+j] +
                                pe_term(act_pipe[i][i+j], w_pipe[j][i+j], bit_cnt, p_reg);
                // Flush slots shift zeros in; a stalled array simply holds.
                if (accept || flush_adv) begin
                    for (int i = 0; i < ROWS; i++) begin
                        act_pipe[i][0] <= accept ? $signed(act_in[i*ACT_WIDTH +: ACT_WIDTH]) : '0;
                        for (int d = 1; d < DEPTH; d++) act_pipe[i][d] <= act_pipe[i][d-1];
                    end
                    for (int j = 0; j < COLS; j++) begin
                        w_pipe[j][0] <= accept ? w_in[j*MAX_PREC +: MAX_PREC] : '0;
                        for (int d = 1; d < DEPTH; d++) w_pipe[j][d] <= w_pipe[j][d-1];
                    end
                    slot_active <= 1'b1;
                    bit_cnt     <= '0;
                end else if (slot_end) begin
                    slot_active <= 1'b0;
                    bit_cnt     <= '0;
                end else if (slot_active) begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (accept)    term_cnt  <= term_cnt + 16'd1;
                if (flush_adv) flush_cnt <= flush_cnt + 16'd1;
                if (drain_fire) idx_reg <= drain_last ? 16'd0 : idx_reg + 16'd1;
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (state == DRAIN)
            for (int n = 0; n < NPE; n++)
                if (idx_reg == 16'(n)) out_data = acc[n];
    end

`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0] cyc_reg;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           cyc_reg <= '0;
        else if (start_acc) cyc_reg <= '0;
        else if (busy)      cyc_reg <= cyc_reg + 32'd1;
    end
    assign cycle_count = cyc_reg;
`else
    assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_systolic_bs_array.sv
// tb/tb_systolic_bs_array.sv - directed self-checking bench for systolic_bs_array (2x2).
module tb_systolic_bs_array;
    localparam int ROWS = 2, COLS = 2, AW = 16, CW = 32, MP = 8;

    logic               clk = 0, rst = 0, start = 0;
    logic [3:0]         precision = 0;
    logic [15:0]        k_len = 0;
    logic               in_valid = 0, in_ready;
    logic [ROWS*AW-1:0] act_in = '0;
    logic [COLS*MP-1:0] w_in = '0;
    logic               out_valid, out_ready = 1;
    logic [CW-1:0]      out_data;
    logic [15:0]        out_idx;
    logic               busy, done;
    logic [31:0]        cycle_count;

    int errors = 0, checks = 0, cyc = 0;

    always #5 clk = ~clk;

    systolic_bs_array #(.ROWS(ROWS), .COLS(COLS), .ACT_WIDTH(AW), .ACC_WIDTH(CW), .MAX_PREC(MP)) dut (
        .clk(clk), .rst(rst), .start(start), .precision(precision), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .w_in(w_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done), .cycle_count(cycle_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d (0x%08h) expected=%0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic logic [31:0] cc_exp(input int n);
`ifdef SYSTOLIC_PERF_CNT_EN
        return 32'(n);
`else
        return 32'd0 + 32'(n - n);
`endif
    endfunction

    task automatic tick();
        @(posedge clk); #1; cyc++;
    endtask

    task automatic start_job(input logic [3:0] p, input logic [15:0] k);
        precision = p; k_len = k; start = 1; cyc = 0;
        tick();
        start = 0;
    endtask

    task automatic send(input logic [ROWS*AW-1:0] a, input logic [COLS*MP-1:0] w);
        int n = 0;
        act_in = a; w_in = w; in_valid = 1;
        while (!in_ready && n < 200) begin tick(); n++; end
        check("in_ready_seen", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 0;
    endtask

    task automatic wait_out(input string tag, input int exp_cyc);
        int n = 0;
        while (!out_valid && n < 500) begin tick(); n++; end
        check(tag, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic drain(input logic [31:0] e0, e1, e2, e3, input int hold, input int cc);
        logic [31:0] e[4];
        e = '{e0, e1, e2, e3};
        for (int b = 0; b < 4; b++) begin
            if (b == hold) begin
                out_ready = 0;
                for (int h = 0; h < 3; h++) begin
                    check("hold_valid", {31'd0, out_valid}, 32'd1);
                    check("hold_idx", {16'd0, out_idx}, 32'(b));
                    check("hold_data", out_data, e[b]);
                    tick();
                end
                out_ready = 1;
            end
            check("beat_valid", {31'd0, out_valid}, 32'd1);
            check("beat_idx", {16'd0, out_idx}, 32'(b));
            check("beat_data", out_data, e[b]);
            tick();
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("valid_after", {31'd0, out_valid}, 32'd0);
        check("cycle_count", cycle_count, cc_exp(cc));
        tick();
        check("done_once", {31'd0, done}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_out_idx"}, {16'd0, out_idx}, 32'd0);
        check({tag, "_cycle_count"}, cycle_count, 32'd0);
    endtask

    initial begin
        int seen;
        #12;
        check_all_zero("reset");
        rst = 1;
        tick();

        // K=1, P=4: single outer-product term
        start_job(4'd4, 16'd1);
        check("busy_start", {31'd0, busy}, 32'd1);
        send({16'hFFFE, 16'd3}, {8'hFF, 8'h05});
        wait_out("first_valid_a", 14);
        drain(32'd15, -32'sd3, -32'sd10, 32'd2, -1, 17);

        // K=3, P=8, extreme negative weight, no stalls
        start_job(4'd8, 16'd3);
        for (int t = 0; t < 3; t++) send({16'd100, 16'd100}, {8'h80, 8'h80});
        wait_out("first_valid_b", 42);
        drain(-32'sd38400, -32'sd38400, -32'sd38400, -32'sd38400, -1, 45);

        // K=3, P=8, 5-cycle input stall at the second slot boundary, out_ready held low on beat 1
        start_job(4'd8, 16'd3);
        send({16'd2, 16'd1}, {8'd4, 8'd3});
        seen = 0;
        while (!in_ready && seen < 50) begin tick(); seen++; end
        check("stall_ready_cycle", 32'(cyc), 32'd9);
        for (int s = 0; s < 5; s++) tick();
        send({16'hFFFA, 16'd5}, {8'd8, 8'hF9});
        send({16'hFF9C, 16'd100}, {8'h80, 8'h7F});
        wait_out("first_valid_c", 47);
        drain(32'd12668, -32'sd12756, -32'sd12652, 32'd12760, 1, 53);

        // K=0 emits zeros even after a nonzero job
        start_job(4'd1, 16'd0);
        check("k0_first_valid", {31'd0, out_valid}, 32'd1);
        drain(32'd0, 32'd0, 32'd0, 32'd0, -1, 4);

        // precision=1 is clamped to 2; high lane bits are ignored
        start_job(4'd1, 16'd1);
        send({16'hFFFD, 16'd7}, {8'h56, 8'hA5});
        wait_out("first_valid_p1", 8);
        drain(32'd7, -32'sd14, -32'sd3, 32'd6, -1, 11);

        // reset in the middle of COMPUTE
        start_job(4'd8, 16'd3);
        send({16'd100, 16'd100}, {8'h80, 8'h80});
        tick(); tick();
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 0;
        tick();
        check_all_zero("midrst");
        rst = 1;
        seen = 0;
        for (int s = 0; s < 60; s++) begin
            if (out_valid || busy) seen++;
            tick();
        end
        check("no_partial_after_rst", 32'(seen), 32'd0);

        start_job(4'd4, 16'd1);
        send({16'hFFFE, 16'd3}, {8'hFF, 8'h05});
        wait_out("first_valid_fresh", 14);
        drain(32'd15, -32'sd3, -32'sd10, 32'd2, -1, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/systolic_bs_array.md
SYSTOLIC_BS_ARRAY -- requirements
Module: systolic_bs_array

Interface
REQ-001 Parameter ROWS, default 4: number of PE rows; one activation lane per row.
REQ-002 Parameter COLS, default 4: number of PE columns; one weight lane per column.
REQ-003 Parameter ACT_WIDTH, default 16: signed integer activation width.
REQ-004 Parameter ACC_WIDTH, default 32: signed accumulator width.
REQ-005 Parameter MAX_PREC, default 8: maximum weight precision in bits.
REQ-006 Port clk, input, 1 bit: clock; all state is updated on the rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port start, input, 1 bit: begin a job; sampled only in IDLE.
REQ-009 Port precision, input, 4 bits: weight precision P; latched at start.
REQ-010 Port k_len, input, 16 bits: number of dot-product terms K; latched at start.
REQ-011 Port in_valid / in_ready, input / output, 1 bit each: term handshake.
REQ-012 Port act_in, input, ROWS*ACT_WIDTH bits: one activation per row; row r occupies bits [r*ACT_WIDTH +: ACT_WIDTH].
REQ-013 Port w_in, input, COLS*MAX_PREC bits: one two's-complement weight per column; only the low P bits of each lane are used.
REQ-014 Port out_valid / out_ready, output / input, 1 bit each: result handshake.
REQ-015 Port out_data, output, ACC_WIDTH bits: result value; port out_idx, output, 16 bits: row-major PE index of the result.
REQ-016 Port busy, output, 1 bit: high whenever the FSM is not in IDLE; port done, output, 1 bit: one-cycle completion pulse.
REQ-017 Port cycle_count, output, 32 bits: performance counter (see Configuration).

Function
REQ-018 FSM states: IDLE, COMPUTE, FLUSH, DRAIN.
- IDLE->COMPUTE on start when K>0.
- IDLE->DRAIN on start when K=0.
- Start in any other state is ignored.
REQ-019 P clamping: precision<2 is used as 2; precision>MAX_PREC is used as MAX_PREC.
REQ-020 On start acceptance, every accumulator clears to 0.
REQ-021 in_ready is high only in COMPUTE, at a slot boundary, while accepted terms < K; a term transfers when in_valid and in_ready are both high.
REQ-022 Slot timing: a term accepted in cycle c is processed bit-serially by PE(0,0) in cycles c+1..c+P; in_ready may be high again in cycle c+P, giving a sustained rate of one term per P cycles.
REQ-023 Stall: if in_valid is low at a slot boundary in COMPUTE, the whole array freezes; no bits are processed and no data moves.
REQ-024 Systolic movement: activations shift one PE right and weights one PE down per slot, so PE(i,j) processes term t in slot t+i+j.
REQ-025 PE arithmetic per weight bit b (LSB first):
- acc += act<<b for b<P-1;
- acc -= act<<(P-1) for the MSB.
- Result is sum over k of act[i][k]*signext(w[j][k]), wrapping modulo 2^ACC_WIDTH.
REQ-026 After the Kth term is accepted, the FSM enters FLUSH and injects ROWS+COLS-2 zero slots without handshake; it then enters DRAIN.
REQ-027 With no stalls, the first out_valid is asserted in cycle 2+(K+ROWS+COLS-2)*P, counting start at cycle 0.
REQ-028 DRAIN output order:
- emits ROWS*COLS beats in row-major order, out_idx = i*COLS+j;
- out_data and out_idx are held while out_valid && !out_ready.
REQ-029 done pulses for one cycle in the cycle after the last beat is accepted, and the FSM returns to IDLE in that same cycle.
REQ-030 For K=0, DRAIN emits ROWS*COLS zero results.

Reset
REQ-031 When rst is low:
- FSM enters IDLE;
- all accumulators, skew registers and counters clear;
- in_ready, out_valid, busy, done, out_data, out_idx and cycle_count are all 0.
REQ-032 Reset mid-job aborts the job; no partial results are emitted after release.

Configuration
REQ-033 Macro SYSTOLIC_PERF_CNT_EN defined: cycle_count clears on start acceptance, increments every cycle while busy, and holds its value in IDLE.
REQ-034 Macro SYSTOLIC_PERF_CNT_EN undefined: cycle_count is tied to 0 and no counter logic is generated; the port list is unchanged.

Verification
REQ-035 ROWS=COLS=2, P=4, K=1, act=(3,-2), w=(5,-1) -> outputs: idx0=15, idx1=-3, idx2=-10, idx3=2; then done pulses.
REQ-036 ROWS=COLS=2, P=8, K=3 with all acts 100 and all weights -128, no stalls -> all four results are -38400; first out_valid in cycle 2+5*8=42.
REQ-037 in_valid low for 5 cycles at the second slot boundary -> results unchanged; first out_valid is delayed by exactly 5 cycles.
REQ-038 out_ready low for 3 cycles on beat 1 -> out_data and out_idx held stable; all 4 beats delivered in order; done after the last beat.
REQ-039 K=0 -> 4 zero beats, then done; precision=1 -> behaves exactly as precision=2.
REQ-040 rst low during COMPUTE -> all outputs 0 next cycle; a fresh job after release gives correct results; with the macro defined, cycle_count equals busy cycles of the fresh job.
